sram_ws_ctrl: RTL and testbench

Clocked static-RAM bank of 2^N locations × M bits, split into L independently writable lanes, with a programmable number of wait states per access and an explicit ready handshake. It replaces the purely combinational latch bank on the processor bus. Accesses are requested with the active-low select/read/write strobes and completed with a one-cycle `ready` pulse. Bus-side tristating stays outside the block: the block drives `data_out` plus an output enable.

---
 rtl/sram_pkg.sv | 17 +
 rtl/sram_array.sv | 33 +++
 rtl/sram_ws_ctrl.sv | 119 +++++++++++
 tb/tb_sram_ws_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared constants for the wait-state SRAM controller: state codes,
// wait-counter sizing and the lane-width helper.
package sram_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    localparam int MAX_WAIT = 15;
    localparam int CNT_W    = 4;   // holds 0..MAX_WAIT

    function automatic int lane_width(input int m, input int l);
        return m / l;
    endfunction

endpackage

// File: rtl/sram_array.sv
// 2^N x M storage with lane-masked synchronous write and asynchronous read.
module sram_array
    import sram_pkg::*;
#(
    parameter int N = 4,
    parameter int M = 16,
    parameter int L = 2
) (
    input  logic         clock,
    input  logic         we,
    input  logic [N-1:0] addr,
    input  logic [L-1:0] be_,
    input  logic [M-1:0] wdata,
    output logic [M-1:0] rdata
);

    localparam int LW = lane_width(M, L);

    logic [M-1:0] mem [2**N];

    // Write only the lanes whose active-low enable is asserted.
    always_ff @(posedge clock) begin
        if (we) begin
            for (int i = 0; i < L; i++) begin
                if (!be_[i])
                    mem[addr][i*LW +: LW] <= wdata[i*LW +: LW];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/sram_ws_ctrl.sv
// Bus-side controller for a clocked SRAM bank: strobe decode, request
// capture, programmable wait states and a one-cycle ready handshake.
module sram_ws_ctrl
    import sram_pkg::*;
#(
    parameter int N = 4,
    parameter int M = 16,
    parameter int L = 2,
    parameter int W = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         s_,
    input  logic         mr_,
    input  logic         mw_,
    input  logic [N-1:0] addr,
    input  logic [M-1:0] data_in,
    input  logic [L-1:0] be_,
    output logic [M-1:0] data_out,
    output logic         data_oe,
    output logic         ready
);

    // Counter preload; W=0 never enters WAIT so the value is unused there.
    localparam logic [CNT_W-1:0] WLOAD = (W > 0) ? CNT_W'(W - 1) : '0;

    logic [1:0]       state;
    logic [CNT_W-1:0] wcnt;
    logic [N-1:0]     cap_addr;
    logic [M-1:0]     cap_data;
    logic [L-1:0]     cap_be;
    logic             cap_wr;

    logic             req;
    logic             commit;
    logic             acc_wr;
    logic [N-1:0]     acc_addr;
    logic [M-1:0]     acc_data;
    logic [L-1:0]     acc_be;
    logic [M-1:0]     rdata;

    // A request needs select plus exactly one of read/write.
    assign req = !s_ && (mr_ ^ mw_);

    // With W=0 the capture edge is also the commit edge, so the array must
    // see the live bus; otherwise it sees the captured request.
    always_comb begin
        acc_wr   = cap_wr;
        acc_addr = cap_addr;
        acc_data = cap_data;
        acc_be   = cap_be;
        if (state == ST_IDLE) begin
            acc_wr   = !mw_;
            acc_addr = addr;
            acc_data = data_in;
            acc_be   = be_;
        end
    end

    // Commit happens on the edge that enters DONE.
    assign commit = ((state == ST_IDLE) && req && (W == 0)) ||
                    ((state == ST_WAIT) && (wcnt == '0));

    // Access sequencing and wait counting.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            wcnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: if (req) begin
                    wcnt  <= WLOAD;
                    state <= (W == 0) ? ST_DONE : ST_WAIT;
                end
                ST_WAIT: begin
                    if (wcnt == '0) state <= ST_DONE;
                    else            wcnt  <= wcnt - 1'b1;
                end
                ST_DONE: state <= ST_HOLD;
                ST_HOLD: if (s_) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Latch the request so later bus activity cannot disturb the access.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cap_addr <= '0;
            cap_data <= '0;
            cap_be   <= '1;
            cap_wr   <= 1'b0;
        end else if ((state == ST_IDLE) && req) begin
            cap_addr <= addr;
            cap_data <= data_in;
            cap_be   <= be_;
            cap_wr   <= !mw_;
        end
    end

    // Read data is registered at commit and held until the next read.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                data_out <= '0;
        else if (commit && !acc_wr) data_out <= rdata;
    end

    assign ready   = (state == ST_DONE);
    assign data_oe = (state == ST_DONE) && !cap_wr;

    sram_array #(.N(N), .M(M), .L(L)) u_array (
        .clock (clock),
        .we    (commit && acc_wr),
        .addr  (acc_addr),
        .be_   (acc_be),
        .wdata (acc_data),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_sram_ws_ctrl.sv
// Scoreboard bench: three controllers (W = 0, 2, 5) driven one at a time.
module tb_sram_ws_ctrl;

    localparam int WS [3] = '{0, 2, 5};

    typedef struct {
        int          k;
        bit          rd;
        int unsigned cyc;
        logic [15:0] data;
    } exp_t;

    logic        clk;
    logic        rst  [3];
    logic        s_n  [3];
    logic        mr_n [3];
    logic        mw_n [3];
    logic [3:0]  ad   [3];
    logic [15:0] din  [3];
    logic [1:0]  be   [3];
    logic [15:0] dout [3];
    logic        oe   [3];
    logic        rdy  [3];

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc     = 0;
    int          rdy_cnt [3];

    exp_t        sb[$];
    logic [15:0] mm [3][16];
    logic [1:0]  mv [3][16];
    logic [15:0] last_rd [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sram_ws_ctrl #(.N(4), .M(16), .L(2), .W(WS[g])) dut (
            .clock    (clk),
            .reset    (rst[g]),
            .s_       (s_n[g]),
            .mr_      (mr_n[g]),
            .mw_      (mw_n[g]),
            .addr     (ad[g]),
            .data_in  (din[g]),
            .be_      (be[g]),
            .data_out (dout[g]),
            .data_oe  (oe[g]),
            .ready    (rdy[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ready pulse must match the oldest expected completion.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rdy[k] === 1'b1) begin
                rdy_cnt[k]++;
                if (sb.size() == 0 || sb[0].k != k) begin
                    chk("ready_owner", k, (sb.size() == 0) ? 99 : sb[0].k);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("ready_cycle", cyc, e.cyc);
                    chk("data_oe_done", oe[k], e.rd);
                    chk(e.rd ? "read_data" : "data_out_hold", dout[k], e.data);
                end
            end else begin
                chk("data_oe_idle", oe[k], 1'b0);
            end
        end
    end

    // One complete access on controller k; called at a negedge.
    task automatic access(input int k, input bit wr, input logic [3:0] a,
                          input logic [15:0] d, input logic [1:0] b, input int hold_min);
        exp_t e;
        bit   seen;
        int   hold;
        e.k   = k;
        e.rd  = !wr;
        e.cyc = cyc + 1 + WS[k];
        if (wr) begin
            for (int i = 0; i < 2; i++) begin
                if (!b[i]) begin
                    mm[k][a][i*8 +: 8] = d[i*8 +: 8];
                    mv[k][a][i]        = 1'b1;
                end
            end
            e.data = last_rd[k];
        end else begin
            e.data     = mm[k][a];
            last_rd[k] = mm[k][a];
        end
        sb.push_back(e);
        s_n[k] = 1'b0; mr_n[k] = wr; mw_n[k] = !wr;
        ad[k] = a; din[k] = d; be[k] = b;
        @(posedge clk);
        #1;
        // Scramble the bus mid-access; only s_ stays low.
        ad[k]   = 4'($urandom);
        din[k]  = 16'($urandom);
        be[k]   = 2'($urandom);
        mr_n[k] = 1'($urandom);
        mw_n[k] = 1'($urandom);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = (rdy[k] === 1'b1);
        end
        if (!seen) begin
            chk("ready_timeout", 32'd0, 32'd1);
            sb.delete();
        end
        hold = hold_min + $urandom_range(0, 2);
        repeat (hold) @(negedge clk);
        s_n[k] = 1'b1; mr_n[k] = 1'b1; mw_n[k] = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int c0;
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; s_n[k] = 1'b1; mr_n[k] = 1'b1; mw_n[k] = 1'b1;
            ad[k] = '0; din[k] = '0; be[k] = '1;
            last_rd[k] = '0; rdy_cnt[k] = 0;
            for (int a = 0; a < 16; a++) begin
                mm[k][a] = '0;
                mv[k][a] = '0;
            end
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("reset_ready", rdy[k], 1'b0);
            chk("reset_oe", oe[k], 1'b0);
            chk("reset_dout", dout[k], 16'h0000);
        end
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        @(negedge clk);

        // W=2: basic write/read, lane mask, address wrap.
        access(1, 1, 4'd5,  16'hA55A, 2'b00, 0);
        access(1, 0, 4'd5,  16'h0000, 2'b00, 0);
        chk("model_a55a", last_rd[1], 16'hA55A);
        access(1, 1, 4'd3,  16'h1234, 2'b00, 0);
        access(1, 1, 4'd3,  16'hFFFF, 2'b10, 1);
        access(1, 0, 4'd3,  16'h0000, 2'b00, 0);
        chk("model_lane", last_rd[1], 16'h12FF);
        access(1, 1, 4'd15, 16'h1111, 2'b00, 0);
        access(1, 1, 4'd0,  16'h2222, 2'b00, 0);
        access(1, 0, 4'd15, 16'h0000, 2'b00, 0);
        access(1, 0, 4'd0,  16'h0000, 2'b00, 0);

        // Invalid strobe combinations must never start an access.
        c0 = rdy_cnt[1];
        s_n[1] = 1'b0; mr_n[1] = 1'b0; mw_n[1] = 1'b0; ad[1] = 4'd5; din[1] = 16'hDEAD; be[1] = 2'b00;
        repeat (10) @(negedge clk);
        mr_n[1] = 1'b1; mw_n[1] = 1'b1;
        repeat (10) @(negedge clk);
        s_n[1] = 1'b1;
        repeat (2) @(negedge clk);
        chk("invalid_no_ready", rdy_cnt[1] - c0, 0);
        access(1, 0, 4'd5, 16'h0000, 2'b00, 0);

        // W=0: single-cycle access; s_ held low through HOLD.
        access(0, 1, 4'd7, 16'hCAFE, 2'b00, 0);
        access(0, 0, 4'd7, 16'h0000, 2'b00, 4);

        // W=5: reset in the middle of a write discards it.
        access(2, 1, 4'd9, 16'h0001, 2'b00, 0);
        s_n[2] = 1'b0; mr_n[2] = 1'b1; mw_n[2] = 1'b0; ad[2] = 4'd9; din[2] = 16'hBEEF; be[2] = 2'b00;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1 rst[2] = 1'b1;
        last_rd[2] = '0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_mid_ready", rdy[2], 1'b0);
            chk("rst_mid_oe", oe[2], 1'b0);
            chk("rst_mid_dout", dout[2], 16'h0000);
        end
        s_n[2] = 1'b1; mw_n[2] = 1'b1; rst[2] = 1'b0;
        @(negedge clk);
        access(2, 0, 4'd9, 16'h0000, 2'b00, 0);
        chk("model_rst_write", last_rd[2], 16'h0001);

        // Random traffic against the reference model.
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 25; n++) begin
                logic [3:0]  a;
                logic [15:0] d;
                logic [1:0]  b;
                bit          wr;
                a  = 4'($urandom);
                d  = 16'($urandom);
                b  = 2'($urandom);
                wr = ($urandom_range(0, 1) == 1) || (mv[k][a] != 2'b11);
                access(k, wr, a, d, b, 0);
            end
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
